// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, access-width encoding and
// the operand-fetch sequencer state type.
package cpu_pkg;

  localparam int DATA_W    = 20;
  localparam int HALF_W    = 10;
  localparam int NUM_REGS  = 6;
  localparam int RF_ADDR_W = 10;
  localparam int IDX_W     = 3;
  localparam int SEL_W     = 2;

  localparam logic [SEL_W-1:0] SEL_FULL = 2'b00;
  localparam logic [SEL_W-1:0] SEL_HI   = 2'b01;
  localparam logic [SEL_W-1:0] SEL_LO   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_CAP_B,
    ST_OPV,
    ST_WB
  } of_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] src_a;
    logic [SEL_W-1:0] src_a_sel;
    logic [IDX_W-1:0] src_b;
    logic [SEL_W-1:0] src_b_sel;
    logic [IDX_W-1:0] dst;
    logic [SEL_W-1:0] dst_sel;
    logic             dst_en;
  } of_req_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decoder, execute, writeback and register-file signals of the operand-fetch
// sequencer. The master modport is the sequencer side.
interface operand_fetch_if;
  import cpu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [IDX_W-1:0]     src_a;
  logic [IDX_W-1:0]     src_b;
  logic [IDX_W-1:0]     dst;
  logic [SEL_W-1:0]     src_a_sel;
  logic [SEL_W-1:0]     src_b_sel;
  logic [SEL_W-1:0]     dst_sel;
  logic                 dst_en;

  logic                 op_valid;
  logic                 op_ready;
  logic [DATA_W-1:0]    op_a;
  logic [DATA_W-1:0]    op_b;
  logic                 op_err;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [DATA_W-1:0]    wb_data;

  logic [RF_ADDR_W-1:0] rf_addr;
  logic [SEL_W-1:0]     rf_sel;
  logic                 rf_we;
  logic [DATA_W-1:0]    rf_wdata;
  logic [DATA_W-1:0]    rf_rdata;

  modport master (
    input  req_valid, src_a, src_b, dst, src_a_sel, src_b_sel, dst_sel, dst_en,
    output req_ready,
    output op_valid, op_a, op_b, op_err,
    input  op_ready,
    input  wb_valid, wb_data,
    output wb_ready,
    output rf_addr, rf_sel, rf_we, rf_wdata,
    input  rf_rdata
  );

  modport slave (
    output req_valid, src_a, src_b, dst, src_a_sel, src_b_sel, dst_sel, dst_en,
    input  req_ready,
    input  op_valid, op_a, op_b, op_err,
    output op_ready,
    output wb_valid, wb_data,
    input  wb_ready,
    input  rf_addr, rf_sel, rf_we, rf_wdata,
    output rf_rdata
  );

endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch sequencer: reads two source registers through the single
// register-file port, hands them to execute, then writes the result back.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  operand_fetch_if.master bus
);

  of_state_e         state_q, state_d;
  of_req_t           req_q, req_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              op_err_q, op_err_d;

  function automatic logic reg_legal(input logic [IDX_W-1:0] idx,
                                     input logic [SEL_W-1:0] sel);
    return (int'(idx) < NUM_REGS) && (sel != SEL_ILL);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_err_q <= op_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_err_d = op_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.src_a     = bus.src_a;
          req_d.src_a_sel = bus.src_a_sel;
          req_d.src_b     = bus.src_b;
          req_d.src_b_sel = bus.src_b_sel;
          req_d.dst       = bus.dst;
          req_d.dst_sel   = bus.dst_sel;
          req_d.dst_en    = bus.dst_en;
          op_err_d        = !reg_legal(bus.src_a, bus.src_a_sel) ||
                            !reg_legal(bus.src_b, bus.src_b_sel);
          state_d         = ST_RD_A;
        end
      end
      ST_RD_A:  state_d = ST_RD_B;
      // Read data lags the address by one cycle, so each capture happens in
      // the state after its address phase.
      ST_RD_B: begin
        op_a_d  = reg_legal(req_q.src_a, req_q.src_a_sel) ? bus.rf_rdata : '0;
        state_d = ST_CAP_B;
      end
      ST_CAP_B: begin
        op_b_d  = reg_legal(req_q.src_b, req_q.src_b_sel) ? bus.rf_rdata : '0;
        state_d = ST_OPV;
      end
      ST_OPV: begin
        if (bus.op_ready) state_d = req_q.dst_en ? ST_WB : ST_IDLE;
      end
      ST_WB: begin
        if (bus.wb_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.op_valid  = (state_q == ST_OPV);
    bus.wb_ready  = (state_q == ST_WB);
    bus.rf_addr   = '0;
    bus.rf_sel    = SEL_FULL;
    bus.rf_we     = 1'b0;
    bus.rf_wdata  = '0;
    case (state_q)
      ST_RD_A: begin
        bus.rf_addr = RF_ADDR_W'(req_q.src_a);
        bus.rf_sel  = req_q.src_a_sel;
      end
      ST_RD_B: begin
        bus.rf_addr = RF_ADDR_W'(req_q.src_b);
        bus.rf_sel  = req_q.src_b_sel;
      end
      ST_WB: begin
        // An illegal destination still completes the handshake, just unwritten.
        if (bus.wb_valid) begin
          bus.rf_addr  = RF_ADDR_W'(req_q.dst);
          bus.rf_sel   = req_q.dst_sel;
          bus.rf_wdata = bus.wb_data;
          bus.rf_we    = reg_legal(req_q.dst, req_q.dst_sel);
        end
      end
      default: ;
    endcase
  end

  assign bus.op_a   = op_a_q;
  assign bus.op_b   = op_b_q;
  assign bus.op_err = op_err_q;

endmodule
